// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage and IF/ID register.
package fetch_pkg;

  localparam int PC_W_DEF = 16;
  localparam int INSTR_W  = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage (master) and memory (slave).
interface fetch_if_id_stage_if #(
  parameter int PC_W = 16
);
  import fetch_pkg::*;

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, hold freezes, load captures a fetched word.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               hold,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic               valid
);

  // A bubble keeps the previous pc; valid=0 marks it as meaningless to decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instruction <= NOP_INSTR;
      pc          <= '0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end else if (!hold && load) begin
      instruction <= instr_in;
      pc          <= pc_in;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_if_id_stage.sv
// Fetch stage: PC, fetch FSM and hold buffer feeding the IF/ID register.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_count output.
module fetch_if_id_stage
  import fetch_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       halt,
  input  logic                       branch_taken,
  input  logic [PC_W-1:0]            branch_target,
  fetch_if_id_stage_if.master        imem,
  output logic [INSTR_W-1:0]         instruction_ID,
  output logic [PC_W-1:0]            pc_ID,
  output logic                       valid_ID
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]                stall_count
`endif
);

  fetch_state_t       state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    addr;
  logic               req;
  logic [INSTR_W-1:0] buf_instr;
  logic [PC_W-1:0]    buf_pc;
  logic               buf_valid;

  logic               in_fetch;
  logic               in_hold;
  logic               in_discard;
  logic               redirect;
  logic               empty_slot;
  logic               ifid_load;
  logic               ifid_hold;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ld_instr;
  logic [PC_W-1:0]    ld_pc;
  logic [PC_W-1:0]    pc_plus1;

  assign in_fetch   = (state == FETCH);
  assign in_hold    = (state == HOLD);
  assign in_discard = (state == DISCARD);
  assign pc_plus1   = pc + 1'b1;

  assign imem.req  = req;
  assign imem.addr = addr;

  // Redirect beats a halt: the slot is flushed anyway, so there is nothing to hold.
  assign redirect   = branch_taken && (state != IDLE);
  assign empty_slot = (in_fetch && !imem.ready) || in_discard;
  assign ifid_flush = redirect || (empty_slot && halt);
  assign ifid_hold  = !halt;
  assign ifid_load  = (in_fetch && imem.ready) || (in_hold && buf_valid);
  assign ld_instr   = in_hold ? buf_instr : imem.rdata;
  assign ld_pc      = in_hold ? buf_pc : pc;

  // addr is separate from pc so an open request keeps its address after a redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      addr      <= RESET_PC;
      req       <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= '0;
      buf_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req   <= 1'b1;
          addr  <= pc;
        end
        FETCH: begin
          if (branch_taken) begin
            pc        <= branch_target;
            buf_valid <= 1'b0;
            if (imem.ready) begin
              addr <= branch_target;
            end else begin
              state <= DISCARD;
            end
          end else if (imem.ready) begin
            if (halt) begin
              pc   <= pc_plus1;
              addr <= pc_plus1;
            end else begin
              buf_instr <= imem.rdata;
              buf_pc    <= pc;
              buf_valid <= 1'b1;
              state     <= HOLD;
              req       <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc        <= branch_target;
            addr      <= branch_target;
            buf_valid <= 1'b0;
            state     <= FETCH;
            req       <= 1'b1;
          end else if (halt) begin
            pc        <= pc_plus1;
            addr      <= pc_plus1;
            buf_valid <= 1'b0;
            state     <= FETCH;
            req       <= 1'b1;
          end
        end
        DISCARD: begin
          if (branch_taken) begin
            pc <= branch_target;
          end
          if (imem.ready) begin
            addr  <= branch_taken ? branch_target : pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .PC_W      (PC_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (ifid_load),
    .hold        (ifid_hold),
    .flush       (ifid_flush),
    .instr_in    (ld_instr),
    .pc_in       (ld_pc),
    .instruction (instruction_ID),
    .pc          (pc_ID),
    .valid       (valid_ID)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 16'h0000;
    end else if (!halt && (in_fetch || in_hold) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Directed bench for fetch_if_id_stage: vector table plus hand-written reset/stall sequences.
module tb_fetch_if_id_stage;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  typedef struct {
    bit          halt;
    bit          ready;
    bit          br;
    logic [15:0] tgt;
    bit          req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pcid;
    bit          valid;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        halt;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instruction_ID;
  logic [15:0] pc_ID;
  logic        valid_ID;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int n_cmp;
  int n_fail;

  fetch_if_id_stage_if #(.PC_W(16)) bus ();

  assign bus.rdata = bus.addr ^ 16'hA000;

  fetch_if_id_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .halt           (halt),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (bus.master),
    .instruction_ID (instruction_ID),
    .pc_ID          (pc_ID),
    .valid_ID       (valid_ID)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit h, bit r, bit b, logic [15:0] t, bit q,
                              logic [15:0] a, logic [15:0] i, logic [15:0] p, bit v);
    vec_t x;
    x.halt = h; x.ready = r; x.br = b; x.tgt = t;
    x.req = q; x.addr = a; x.instr = i; x.pcid = p; x.valid = v;
    return x;
  endfunction

  vec_t vq[$];

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset_n = 1'b0;
    halt = 1'b1;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    bus.ready = 1'b1;

    //      halt ready br  tgt      req addr     instr    pc_ID    valid
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0000, 16'h0000, 16'h0000, L)); // IDLE -> FETCH
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0001, 16'hA000, 16'h0000, H));
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0002, 16'hA001, 16'h0001, H));
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0003, 16'hA002, 16'h0002, H));
    vq.push_back(mk(L, H, L, 16'h0000, L, 16'h0003, 16'hA002, 16'h0002, H)); // capture -> HOLD
    vq.push_back(mk(L, H, L, 16'h0000, L, 16'h0003, 16'hA002, 16'h0002, H));
    vq.push_back(mk(L, H, L, 16'h0000, L, 16'h0003, 16'hA002, 16'h0002, H));
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0004, 16'hA003, 16'h0003, H)); // held word enters
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0005, 16'hA004, 16'h0004, H));
    vq.push_back(mk(H, L, H, 16'h0040, H, 16'h0005, 16'h0000, 16'h0000, L)); // branch, open req
    vq.push_back(mk(H, L, L, 16'h0000, H, 16'h0005, 16'h0000, 16'h0000, L));
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0040, 16'h0000, 16'h0000, L)); // data dropped
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0041, 16'hA040, 16'h0040, H));
    vq.push_back(mk(L, H, H, 16'h0100, H, 16'h0100, 16'h0000, 16'h0000, L)); // branch beats halt
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0101, 16'hA100, 16'h0100, H));
    vq.push_back(mk(L, L, L, 16'h0000, H, 16'h0101, 16'hA100, 16'h0100, H)); // no data, halted
    vq.push_back(mk(H, L, L, 16'h0000, H, 16'h0101, 16'h0000, 16'h0000, L)); // empty fetch bubble
    vq.push_back(mk(L, H, L, 16'h0000, L, 16'h0101, 16'h0000, 16'h0000, L)); // -> HOLD
    vq.push_back(mk(L, H, H, 16'hFFFF, H, 16'hFFFF, 16'h0000, 16'h0000, L)); // branch in HOLD
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0000, 16'h5FFF, 16'hFFFF, H)); // pc wraps
    vq.push_back(mk(H, H, L, 16'h0000, H, 16'h0001, 16'hA000, 16'h0000, H));

    step();
    step();
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_addr", {16'd0, bus.addr}, 32'd0);
    chk("rst_instr", {16'd0, instruction_ID}, 32'h0000);
    chk("rst_pc", {16'd0, pc_ID}, 32'd0);
    chk("rst_valid", {31'd0, valid_ID}, 32'd0);
    $display("reset checked: req=%0b addr=%h instr=%h valid=%0b", bus.req, bus.addr, instruction_ID, valid_ID);
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      halt = vq[i].halt;
      bus.ready = vq[i].ready;
      branch_taken = vq[i].br;
      branch_target = vq[i].tgt;
      step();
      $display("vec %0d: halt=%0b ready=%0b br=%0b -> req=%0b addr=%h instr=%h pc_ID=%h valid=%0b",
               i, vq[i].halt, vq[i].ready, vq[i].br, bus.req, bus.addr, instruction_ID, pc_ID, valid_ID);
      chk($sformatf("v%0d_req", i), {31'd0, bus.req}, {31'd0, vq[i].req});
      chk($sformatf("v%0d_addr", i), {16'd0, bus.addr}, {16'd0, vq[i].addr});
      chk($sformatf("v%0d_instr", i), {16'd0, instruction_ID}, {16'd0, vq[i].instr});
      chk($sformatf("v%0d_valid", i), {31'd0, valid_ID}, {31'd0, vq[i].valid});
      if (vq[i].valid) begin
        chk($sformatf("v%0d_pc", i), {16'd0, pc_ID}, {16'd0, vq[i].pcid});
      end
    end
    branch_taken = 1'b0;

    // Enter HOLD, then pulse reset mid-cycle: outputs must clear without a clock edge.
    halt = 1'b0;
    bus.ready = 1'b1;
    step();
    $display("pre-reset hold: req=%0b instr=%h valid=%0b", bus.req, instruction_ID, valid_ID);
    chk("hold_req", {31'd0, bus.req}, 32'd0);
    chk("hold_instr", {16'd0, instruction_ID}, 32'h0000A000);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_pre", {16'd0, stall_count}, 32'd8);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset: req=%0b addr=%h instr=%h pc_ID=%h valid=%0b", bus.req, bus.addr, instruction_ID, pc_ID, valid_ID);
    chk("areset_req", {31'd0, bus.req}, 32'd0);
    chk("areset_addr", {16'd0, bus.addr}, 32'd0);
    chk("areset_instr", {16'd0, instruction_ID}, 32'h0000);
    chk("areset_pc", {16'd0, pc_ID}, 32'd0);
    chk("areset_valid", {31'd0, valid_ID}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    chk("areset_stall", {16'd0, stall_count}, 32'd0);
`endif
    step();
    reset_n = 1'b1;
    halt = 1'b1;
    step();
    $display("restart idle: req=%0b addr=%h", bus.req, bus.addr);
    chk("restart_req", {31'd0, bus.req}, 32'd1);
    chk("restart_addr", {16'd0, bus.addr}, 32'd0);
    step();
    $display("restart fetch: instr=%h pc_ID=%h valid=%0b", instruction_ID, pc_ID, valid_ID);
    chk("restart_instr", {16'd0, instruction_ID}, 32'h0000A000);
    chk("restart_pc", {16'd0, pc_ID}, 32'd0);
    chk("restart_valid", {31'd0, valid_ID}, 32'd1);

`ifdef FETCH_STALL_CNT_EN
    halt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      $display("stall cycle %0d: stall_count=%0d", k, stall_count);
    end
    chk("stall_5", {16'd0, stall_count}, 32'd5);
    halt = 1'b1;
    step();
    chk("stall_run", {16'd0, stall_count}, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("stall_rst", {16'd0, stall_count}, 32'd0);
    step();
    reset_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_if_id_stage.md
Name: fetch_if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined datapath.
- Owns the PC and issues word fetches over a req/ready instruction-memory handshake.
- Presents instruction_ID/pc_ID to decode and to the load-use hazard detector.
- Obeys the detector's active-low halt (hold) and the EX-stage branch redirect, which flushes the stage.

Parameters:
- PC_W, 16, PC and instruction-address width (word addressed).
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h0000, bubble encoding loaded into IF/ID on flush or empty fetch.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- halt  in  1  from hazard detect; 0 = hold PC and IF/ID, 1 = run.
- branch_taken  in  1  redirect request from EX.
- branch_target  in  PC_W  redirect address.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  imem_rdata valid for the current request this cycle.
- imem_rdata  in  16  fetched instruction.
- instruction_ID  out  16  IF/ID instruction.
- pc_ID  out  PC_W  PC of instruction_ID.
- valid_ID  out  1  instruction_ID is real, not a bubble.

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, state=IDLE, instruction_ID=NOP_INSTR, pc_ID=0, valid_ID=0, imem_req=0, hold buffer empty.
- States:
  - IDLE: one cycle after reset release, no request → FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ready=1 and halt=1: IF/ID <= {rdata, pc, valid=1}; pc <= pc+1; stay.
    - imem_ready=1 and halt=0: rdata/pc captured in hold buffer, IF/ID unchanged → HOLD.
    - imem_ready=0 and halt=1: IF/ID <= bubble (NOP_INSTR, valid=0).
    - imem_ready=0 and halt=0: IF/ID unchanged.
  - HOLD: imem_req=0. While halt=0, IF/ID and buffer hold. On halt=1: IF/ID <= buffer (valid=1), pc <= pc+1 → FETCH.
  - DISCARD: imem_req=1 with the old address until imem_ready=1; returned data dropped → FETCH at the redirected pc.
- Branch (branch_taken=1, any state except IDLE):
  - pc <= branch_target; IF/ID <= bubble; hold buffer cleared.
  - In FETCH with imem_ready=0 → DISCARD, so the address stays stable during the open request.
  - In FETCH with imem_ready=1, or in HOLD → FETCH.
  - In DISCARD: target overwrites pc; stay in DISCARD.
- Branch and halt=0 in the same cycle: branch wins; the flushed slot makes the hold moot.
- Fetch latency: one instruction per cycle when imem_ready is tied high; IF/ID updates on the edge after ready.
- PC wraps 16'hFFFF -> 16'h0000 without error.
- Reset mid-request: request dropped immediately. Memory must tolerate an abandoned request.

Optional Feature:
- FETCH_STALL_CNT_EN defined:
  - Adds output stall_count[15:0].
  - Counts cycles with halt=0 while in FETCH or HOLD; saturates at 16'hFFFF.
  - Async reset to 0; not cleared by branch.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg: state encoding (IDLE, FETCH, HOLD, DISCARD), NOP_INSTR default, PC_W default.
- Sub-module if_id_reg: three controls, load / hold / flush, with priority flush > hold > load. Registers instruction, pc and valid.
- PC, FSM and hold buffer stay in the top module.

Test Plan:
- Reset, imem_ready=1, halt=1, rdata=addr^16'hA000 → after IDLE, instruction_ID sequence A000, A001, A002; pc_ID 0, 1, 2; valid_ID=1.
- halt=0 for 3 cycles with a fetch returned in the first → state HOLD, IF/ID frozen, imem_req=0; on halt=1 the held word enters IF/ID, then fetch resumes at the next pc, with no skipped or duplicated PC.
- imem_ready low 2 cycles, branch_taken to 16'h0040 in cycle 1 → imem_addr held at the old address until ready, data dropped, next request at 0040, valid_ID=0 meanwhile.
- branch_taken and halt=0 in the same cycle → bubble loaded (valid_ID=0), pc=target, no HOLD entry.
- pc=16'hFFFF fetch → next imem_addr=16'h0000.
- reset_n pulsed low mid-HOLD → outputs at reset values immediately; restart fetch at RESET_PC. With FETCH_STALL_CNT_EN: 5 stall cycles → stall_count=5, reset → 0.
